// File: rtl/xor_decrypt_seq_if.sv
// Control and RAM-strobe bundle between the decrypt sequencer and its surroundings.
// The sequencer owns the master side; the host/RAM side uses the slave modport.
interface xor_decrypt_seq_if;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic [3:0] char_idx;
  logic       load_MAR;
  logic       load_MDR;
  logic       CS;
  logic       R_NW;
  logic       MDR_bus;

  modport master (
    input  start,
    input  mode,
    output busy,
    output done,
    output char_idx,
    output load_MAR,
    output load_MDR,
    output CS,
    output R_NW,
    output MDR_bus
  );

  modport slave (
    output start,
    output mode,
    input  busy,
    input  done,
    input  char_idx,
    input  load_MAR,
    input  load_MDR,
    input  CS,
    input  R_NW,
    input  MDR_bus
  );
endinterface

// File: rtl/xor_decrypt_seq.sv
// Bus-master sequencer: fetches a key word, XOR/XNORs N_CHARS encrypted words with it
// and writes the results back through the RAM's MAR/MDR strobe protocol on sysbus.
module xor_decrypt_seq #(
  parameter int WORD_W   = 10,
  parameter int OP_W     = 3,
  parameter int ENC_BASE = 64,
  parameter int DEC_BASE = 72,
  parameter int KEY_ADDR = 80,
  parameter int N_CHARS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  xor_decrypt_seq_if.master bus,
  inout  wire [WORD_W-1:0]  sysbus
);

  localparam int ADDR_W = WORD_W - OP_W;
  localparam int IDX_W  = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_K_MAR,
    S_K_RD,
    S_K_CAP,
    S_C_MAR,
    S_C_RD,
    S_C_CAP,
    S_W_MAR,
    S_W_MDR,
    S_W_WR,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [WORD_W-1:0]  key_q, key_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   char_idx_q, char_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load_mar_q, load_mar_d;
  logic               load_mdr_q, load_mdr_d;
  logic               cs_q, cs_d;
  logic               r_nw_q, r_nw_d;
  logic               mdr_bus_q, mdr_bus_d;
  logic               drive_en_q, drive_en_d;
  logic [WORD_W-1:0]  drive_val_q, drive_val_d;

  // Addresses wrap inside the ADDR_W-bit field and are zero-extended onto the bus.
  function automatic logic [WORD_W-1:0] addr_word(input int base, input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(base) + ADDR_W'(idx);
    return {{OP_W{1'b0}}, a};
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = key_q;
    data_d     = data_q;
    char_idx_d = char_idx_q;

    case (state_q)
      S_IDLE: begin
        char_idx_d = '0;
        if (bus.start) begin
          state_d = S_K_MAR;
          mode_d  = bus.mode;
        end
      end
      S_K_MAR: state_d = S_K_RD;
      S_K_RD:  state_d = S_K_CAP;
      S_K_CAP: begin
        key_d   = sysbus;
        state_d = S_C_MAR;
      end
      S_C_MAR: state_d = S_C_RD;
      S_C_RD:  state_d = S_C_CAP;
      S_C_CAP: begin
        data_d  = sysbus ^ key_q ^ {WORD_W{mode_q}};
        state_d = S_W_MAR;
      end
      S_W_MAR: state_d = S_W_MDR;
      S_W_MDR: state_d = S_W_WR;
      S_W_WR: begin
        if (char_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          char_idx_d = char_idx_q + 1'b1;
          state_d    = S_C_MAR;
        end
      end
      S_DONE: begin
        char_idx_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    load_mar_d = (state_d == S_K_MAR) || (state_d == S_C_MAR) || (state_d == S_W_MAR);
    load_mdr_d = (state_d == S_W_MDR);
    cs_d       = (state_d == S_K_RD) || (state_d == S_C_RD) || (state_d == S_W_WR);
    r_nw_d     = (state_d != S_W_WR);
    mdr_bus_d  = (state_d == S_K_CAP) || (state_d == S_C_CAP);
    drive_en_d = load_mar_d || load_mdr_d;

    case (state_d)
      S_K_MAR: drive_val_d = addr_word(KEY_ADDR, '0);
      S_C_MAR: drive_val_d = addr_word(ENC_BASE, char_idx_d);
      S_W_MAR: drive_val_d = addr_word(DEC_BASE, char_idx_d);
      S_W_MDR: drive_val_d = data_d;
      default: drive_val_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      key_q       <= '0;
      data_q      <= '0;
      char_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_mar_q  <= 1'b0;
      load_mdr_q  <= 1'b0;
      cs_q        <= 1'b0;
      r_nw_q      <= 1'b0;
      mdr_bus_q   <= 1'b0;
      drive_en_q  <= 1'b0;
      drive_val_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      data_q      <= data_d;
      char_idx_q  <= char_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_mar_q  <= load_mar_d;
      load_mdr_q  <= load_mdr_d;
      cs_q        <= cs_d;
      r_nw_q      <= r_nw_d;
      mdr_bus_q   <= mdr_bus_d;
      drive_en_q  <= drive_en_d;
      drive_val_q <= drive_val_d;
    end
  end

  assign sysbus       = drive_en_q ? drive_val_q : {WORD_W{1'bz}};
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.char_idx = char_idx_q;
  assign bus.load_MAR = load_mar_q;
  assign bus.load_MDR = load_mdr_q;
  assign bus.CS       = cs_q;
  assign bus.R_NW     = r_nw_q;
  assign bus.MDR_bus  = mdr_bus_q;

endmodule
